// File: rtl/dmem_bridge.sv
// Bridges the single-cycle core data port onto a valid/ready data-memory bus.
// Optional bus watchdog enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic              core_we,
    input  logic              core_re,
    input  logic [2:0]        core_funct3,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    output logic              misalign_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t            state_q, state_d;
    logic              bus_req_valid_q, bus_req_valid_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [31:0]       core_rdata_q, core_rdata_d;

    logic req, aligned, accept, rsp_take, tmo_hit;

    function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] lane_wstrb(input logic [1:0] lo, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [2:0] f3);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lo, 3'b000};
        b       = shifted[7:0];
        h       = lo[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign req = core_we | core_re;

    always_comb begin
        case (core_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~core_addr[0];
            2'b10:   aligned = (core_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign accept   = (state_q == REQ) && bus_req_valid_q && bus_req_ready;
    assign rsp_take = (state_q == WAIT) && bus_rsp_valid;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             in_flight;

    assign in_flight = (state_q == REQ) || (state_q == WAIT);
    assign tmo_hit   = in_flight && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Counter is zero whenever idle, so it starts from zero on every REQ entry.
    always_comb begin
        tmo_cnt_d = in_flight ? tmo_cnt_q + TMO_W'(1) : '0;
        bus_err_d = tmo_hit && !accept && !rsp_take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        bus_req_valid_d = bus_req_valid_q;
        bus_addr_d      = bus_addr_q;
        bus_we_d        = bus_we_q;
        bus_wdata_d     = bus_wdata_q;
        bus_wstrb_d     = bus_wstrb_q;
        funct3_d        = funct3_q;
        addr_lo_d       = addr_lo_q;
        core_rdata_d    = core_rdata_q;
        core_stall      = 1'b0;
        misalign_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && aligned) begin
                    core_stall      = 1'b1;
                    bus_addr_d      = {core_addr[ADDR_W-1:2], 2'b00};
                    addr_lo_d       = core_addr[1:0];
                    bus_we_d        = core_we;
                    funct3_d        = core_funct3;
                    bus_wdata_d     = lane_wdata(core_wdata, core_funct3);
                    bus_wstrb_d     = core_we ? lane_wstrb(core_addr[1:0], core_funct3) : 4'b0000;
                    bus_req_valid_d = 1'b1;
                    state_d         = REQ;
                end else if (req) begin
                    misalign_err = 1'b1;
                    core_rdata_d = '0;
                end
            end
            REQ: begin
                core_stall = 1'b1;
                if (accept) begin
                    bus_req_valid_d = 1'b0;
                    if (bus_we_q) begin
                        core_rdata_d = '0;
                        state_d      = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (tmo_hit) begin
                    bus_req_valid_d = 1'b0;
                    core_rdata_d    = '0;
                    state_d         = DONE;
                end
            end
            WAIT: begin
                core_stall = 1'b1;
                if (rsp_take) begin
                    core_rdata_d = extend_load(bus_rdata, addr_lo_q, funct3_q);
                    state_d      = DONE;
                end else if (tmo_hit) begin
                    core_rdata_d = '0;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            bus_req_valid_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_we_q        <= 1'b0;
            bus_wdata_q     <= '0;
            bus_wstrb_q     <= '0;
            funct3_q        <= '0;
            addr_lo_q       <= '0;
            core_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_addr_q      <= bus_addr_d;
            bus_we_q        <= bus_we_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_wstrb_q     <= bus_wstrb_d;
            funct3_q        <= funct3_d;
            addr_lo_q       <= addr_lo_d;
            core_rdata_q    <= core_rdata_d;
        end
    end

    assign core_rdata    = core_rdata_q;
    assign bus_req_valid = bus_req_valid_q;
    assign bus_addr      = bus_addr_q;
    assign bus_we        = bus_we_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_wstrb     = bus_wstrb_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge; the watchdog section runs only
// when DMEM_BRIDGE_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 8).
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_we;
    logic        core_re;
    logic [2:0]  core_funct3;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        misalign_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    dmem_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_we       (core_we),
        .core_re       (core_re),
        .core_funct3   (core_funct3),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .misalign_err  (misalign_err),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load with ready high on the first REQ cycle and response one cycle later.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] word, input logic [31:0] exp);
        core_addr = addr; core_funct3 = f3; core_re = 1'b1; core_we = 1'b0;
        bus_req_ready = 1'b1;
        #1 chk({tag, "_stall_idle"}, 32'(core_stall), 32'd1);
        tick();
        chk({tag, "_valid"}, 32'(bus_req_valid), 32'd1);
        chk({tag, "_stall_req"}, 32'(core_stall), 32'd1);
        chk({tag, "_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'd0);
        tick();
        bus_rsp_valid = 1'b1; bus_rdata = word;
        #1 chk({tag, "_stall_wait"}, 32'(core_stall), 32'd1);
        chk({tag, "_valid_drop"}, 32'(bus_req_valid), 32'd0);
        tick();
        bus_rsp_valid = 1'b0; core_re = 1'b0; bus_req_ready = 1'b0;
        #1 chk({tag, "_stall_done"}, 32'(core_stall), 32'd0);
        chk({tag, "_rdata"}, core_rdata, exp);
        tick();
    endtask

    // Store accepted on the first REQ cycle; request left high through DONE.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] wd, input logic also_re,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        core_addr = addr; core_funct3 = f3; core_wdata = wd;
        core_we = 1'b1; core_re = also_re; bus_req_ready = 1'b1;
        #1 chk({tag, "_stall_idle"}, 32'(core_stall), 32'd1);
        tick();
        chk({tag, "_valid"}, 32'(bus_req_valid), 32'd1);
        chk({tag, "_we"}, 32'(bus_we), 32'd1);
        chk({tag, "_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'(exp_strb));
        chk({tag, "_wdata"}, bus_wdata, exp_wdata);
        tick();
        chk({tag, "_stall_done"}, 32'(core_stall), 32'd0);
        chk({tag, "_rdata_zero"}, core_rdata, 32'd0);
        tick();
        core_we = 1'b0; core_re = 1'b0; bus_req_ready = 1'b0;
        #1 chk({tag, "_idle_valid"}, 32'(bus_req_valid), 32'd0);
        chk({tag, "_idle_stall"}, 32'(core_stall), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        core_addr = '0; core_wdata = '0; core_we = 1'b0; core_re = 1'b0; core_funct3 = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
        tick();
        tick();
        chk("rst_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        rst_n = 1'b1;
        tick();

        do_load("lw_100", 32'h100, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lb_103", 32'h103, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu_103", 32'h103, 3'b100, 32'h80FF_0000, 32'h0000_0080);
        do_load("lhu_102", 32'h102, 3'b101, 32'h80FF_0000, 32'h0000_80FF);
        do_load("lh_100", 32'h100, 3'b001, 32'h1234_8001, 32'hFFFF_8001);
        do_load("lb_101", 32'h101, 3'b000, 32'h0000_7F00, 32'h0000_007F);

        // SB with ready held low for five REQ cycles; core inputs wander meanwhile.
        core_addr = 32'h201; core_wdata = 32'h1234_5678; core_funct3 = 3'b000;
        core_we = 1'b1; bus_req_ready = 1'b0;
        #1 chk("sb_stall_idle", 32'(core_stall), 32'd1);
        tick();
        core_addr = 32'hFFFF_FFF0; core_wdata = 32'hAAAA_5555; core_funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("sb_valid_%0d", i), 32'(bus_req_valid), 32'd1);
            chk($sformatf("sb_stall_%0d", i), 32'(core_stall), 32'd1);
            chk($sformatf("sb_addr_%0d", i), bus_addr, 32'h200);
            chk($sformatf("sb_wstrb_%0d", i), 32'(bus_wstrb), 32'h2);
            chk($sformatf("sb_wdata_%0d", i), bus_wdata, 32'h7878_7878);
            tick();
        end
        bus_req_ready = 1'b1;
        #1 chk("sb_valid_accept", 32'(bus_req_valid), 32'd1);
        tick();
        core_we = 1'b0; bus_req_ready = 1'b0;
        #1 chk("sb_stall_done", 32'(core_stall), 32'd0);
        chk("sb_valid_done", 32'(bus_req_valid), 32'd0);
        chk("sb_rdata_zero", core_rdata, 32'd0);
        tick();

        do_store("sh_202", 32'h202, 3'b001, 32'hCAFE_BABE, 1'b0, 4'b1100, 32'hBABE_BABE);
        do_store("sw_we_re", 32'h304, 3'b010, 32'h0BAD_F00D, 1'b1, 4'b1111, 32'h0BAD_F00D);

        // Misaligned accesses: rdata made nonzero first so the clear is visible.
        do_load("lw_pre_mis", 32'h104, 3'b010, 32'h1122_3344, 32'h1122_3344);
        core_addr = 32'h102; core_funct3 = 3'b010; core_re = 1'b1;
        #1 chk("mis_lw_err", 32'(misalign_err), 32'd1);
        chk("mis_lw_stall", 32'(core_stall), 32'd0);
        tick();
        core_re = 1'b0;
        #1 chk("mis_lw_valid", 32'(bus_req_valid), 32'd0);
        chk("mis_lw_rdata", core_rdata, 32'd0);
        chk("mis_lw_err_off", 32'(misalign_err), 32'd0);
        core_addr = 32'h001; core_funct3 = 3'b001; core_wdata = 32'h5A5A_5A5A; core_we = 1'b1;
        #1 chk("mis_sh_err", 32'(misalign_err), 32'd1);
        chk("mis_sh_stall", 32'(core_stall), 32'd0);
        tick();
        core_we = 1'b0;
        #1 chk("mis_sh_valid", 32'(bus_req_valid), 32'd0);
        chk("mis_sh_err_off", 32'(misalign_err), 32'd0);
        tick();

        // Reset while waiting for read data, then a stale response after release.
        do_load("lw_pre_rst", 32'h108, 3'b010, 32'h5566_7788, 32'h5566_7788);
        core_addr = 32'h100; core_funct3 = 3'b010; core_re = 1'b1; bus_req_ready = 1'b1;
        tick();
        tick();
        chk("rst_mid_in_wait", 32'(core_stall), 32'd1);
        rst_n = 1'b0; core_re = 1'b0; bus_req_ready = 1'b0;
        #1 chk("rst_mid_stall", 32'(core_stall), 32'd0);
        chk("rst_mid_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_mid_rdata", core_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus_rsp_valid = 1'b1; bus_rdata = 32'hAAAA_AAAA;
        tick();
        bus_rsp_valid = 1'b0;
        #1 chk("rst_late_rdata", core_rdata, 32'd0);
        chk("rst_late_stall", 32'(core_stall), 32'd0);
        chk("rst_late_valid", 32'(bus_req_valid), 32'd0);
        tick();

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        do_load("lw_pre_tmo", 32'h10C, 3'b010, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        core_addr = 32'h500; core_funct3 = 3'b010; core_re = 1'b1; bus_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tmo_stall_%0d", i), 32'(core_stall), 32'd1);
            chk($sformatf("tmo_err_%0d", i), 32'(bus_err), 32'd0);
            chk($sformatf("tmo_valid_%0d", i), 32'(bus_req_valid), 32'd1);
            tick();
        end
        core_re = 1'b0;
        #1 chk("tmo_err_pulse", 32'(bus_err), 32'd1);
        chk("tmo_stall_done", 32'(core_stall), 32'd0);
        chk("tmo_valid_drop", 32'(bus_req_valid), 32'd0);
        chk("tmo_rdata", core_rdata, 32'd0);
        tick();
        chk("tmo_err_off", 32'(bus_err), 32'd0);
        chk("tmo_idle_stall", 32'(core_stall), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
